decode_ctrl_pipe: RTL and testbench

//  Registered successor to the combinational control unit: decodes D-stage opcode fields into control bundle, pipelines it into the ID/EX register.

---
 rtl/decode_ctrl_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32 control decode feeding the ID/EX register, with a mul/div busy
// sequencer, flush and bubble handling. Define CTRL_RV32M_EN to enable RV32M decode and the FSM.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 5
`endif
`ifndef ALU_CONTROL_ADD
`define ALU_CONTROL_ADD    0
`define ALU_CONTROL_SUB    1
`define ALU_CONTROL_AND    2
`define ALU_CONTROL_OR     3
`define ALU_CONTROL_XOR    4
`define ALU_CONTROL_SLT    5
`define ALU_CONTROL_SLTU   6
`define ALU_CONTROL_SLL    7
`define ALU_CONTROL_SRL    8
`define ALU_CONTROL_SRA    9
`define ALU_CONTROL_MUL    10
`define ALU_CONTROL_MULH   11
`define ALU_CONTROL_MULHSU 12
`define ALU_CONTROL_MULHU  13
`define ALU_CONTROL_DIV    14
`define ALU_CONTROL_DIVU   15
`define ALU_CONTROL_REM    16
`define ALU_CONTROL_REMU   17
`endif

package decode_ctrl_pipe_pkg;
    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S, IMM_B, IMM_U, IMM_J} immediate_type_e;
    typedef enum logic [1:0] {ALU_A_RS1 = 2'd0, ALU_A_PC, ALU_A_ZERO} alu_a_src_sel_e;
    typedef enum logic {PC_TGT_PC = 1'b0, PC_TGT_RS1} pc_target_src_sel_e;
endpackage

module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int ALU_CTRL_W = `ALU_CONTROL_WIDTH,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_d_i,
    input  logic [6:0]             op_d_i,
    input  logic [2:0]             funct3_d_i,
    input  logic                   funct7_5_d_i,
    input  logic                   funct7_0_d_i,
    input  logic                   hazard_stall_i,
    input  logic                   flush_e_i,
    output logic                   valid_e_o,
    output logic                   reg_write_e_o,
    output logic [1:0]             result_src_e_o,
    output logic                   mem_write_e_o,
    output logic                   jump_e_o,
    output logic                   branch_e_o,
    output logic                   alu_src_e_o,
    output logic [ALU_CTRL_W-1:0]  alu_control_e_o,
    output immediate_type_e        imm_type_e_o,
    output logic [2:0]             funct3_e_o,
    output alu_a_src_sel_e         op_a_sel_e_o,
    output pc_target_src_sel_e     pc_target_src_sel_e_o,
    output logic                   illegal_e_o,
    output logic                   muldiv_start_e_o,
    output logic                   muldiv_done_e_o,
    output logic                   stall_req_o
);

    if (MULDIV_LAT < 2 || MULDIV_LAT > 16 || (MULDIV_LAT - 1) >= (1 << CNT_W)) begin : g_param_check
        $error("decode_ctrl_pipe: MULDIV_LAT must be 2..16 and fit in CNT_W bits");
    end

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(`ALU_CONTROL_ADD);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(`ALU_CONTROL_SUB);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(`ALU_CONTROL_AND);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(`ALU_CONTROL_OR);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(`ALU_CONTROL_XOR);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(`ALU_CONTROL_SLT);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(`ALU_CONTROL_SLTU);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(`ALU_CONTROL_SLL);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(`ALU_CONTROL_SRL);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(`ALU_CONTROL_SRA);

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  alu_src;
        logic [ALU_CTRL_W-1:0] alu_control;
        immediate_type_e       imm_type;
        logic [2:0]            funct3;
        alu_a_src_sel_e        op_a_sel;
        pc_target_src_sel_e    pc_target_src_sel;
        logic                  illegal;
    } ctrl_t;

    ctrl_t dec;
    ctrl_t ctrl_e;
    logic  valid_e;
    logic  busy;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [ALU_CTRL_W-1:0] int_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  int_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  int_alu = ALU_SLL;
            3'b010:  int_alu = ALU_SLT;
            3'b011:  int_alu = ALU_SLTU;
            3'b100:  int_alu = ALU_XOR;
            3'b101:  int_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  int_alu = ALU_OR;
            default: int_alu = ALU_AND;
        endcase
    endfunction

`ifdef CTRL_RV32M_EN
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL    = ALU_CTRL_W'(`ALU_CONTROL_MUL);
    localparam logic [ALU_CTRL_W-1:0] ALU_MULH   = ALU_CTRL_W'(`ALU_CONTROL_MULH);
    localparam logic [ALU_CTRL_W-1:0] ALU_MULHSU = ALU_CTRL_W'(`ALU_CONTROL_MULHSU);
    localparam logic [ALU_CTRL_W-1:0] ALU_MULHU  = ALU_CTRL_W'(`ALU_CONTROL_MULHU);
    localparam logic [ALU_CTRL_W-1:0] ALU_DIV    = ALU_CTRL_W'(`ALU_CONTROL_DIV);
    localparam logic [ALU_CTRL_W-1:0] ALU_DIVU   = ALU_CTRL_W'(`ALU_CONTROL_DIVU);
    localparam logic [ALU_CTRL_W-1:0] ALU_REM    = ALU_CTRL_W'(`ALU_CONTROL_REM);
    localparam logic [ALU_CTRL_W-1:0] ALU_REMU   = ALU_CTRL_W'(`ALU_CONTROL_REMU);

    function automatic logic [ALU_CTRL_W-1:0] md_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  md_alu = ALU_MUL;
            3'b001:  md_alu = ALU_MULH;
            3'b010:  md_alu = ALU_MULHSU;
            3'b011:  md_alu = ALU_MULHU;
            3'b100:  md_alu = ALU_DIV;
            3'b101:  md_alu = ALU_DIVU;
            3'b110:  md_alu = ALU_REM;
            default: md_alu = ALU_REMU;
        endcase
    endfunction
`endif

    always_comb begin
        dec        = '0;
        dec.funct3 = funct3_d_i;
        case (op_d_i)
            OP_LOAD: begin
                dec.reg_write   = 1'b1;
                dec.result_src  = RES_MEM;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm_type    = IMM_I;
                dec.illegal     = (funct3_d_i == 3'b011) || (funct3_d_i[2:1] == 2'b11);
            end
            OP_STORE: begin
                dec.mem_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.imm_type    = IMM_S;
                dec.illegal     = funct3_d_i[2] || (funct3_d_i[1:0] == 2'b11);
            end
            OP_REG: begin
                dec.reg_write = 1'b1;
                if (funct7_0_d_i) begin
`ifdef CTRL_RV32M_EN
                    dec.alu_control = md_alu(funct3_d_i);
`else
                    dec.illegal = 1'b1;
`endif
                end else begin
                    dec.alu_control = int_alu(funct3_d_i, funct7_5_d_i);
                end
            end
            OP_IMM: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.imm_type    = IMM_I;
                dec.alu_control = int_alu(funct3_d_i, funct7_5_d_i && (funct3_d_i == 3'b101));
            end
            OP_BRANCH: begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                dec.imm_type    = IMM_B;
                dec.illegal     = (funct3_d_i[2:1] == 2'b01);
            end
            OP_JAL: begin
                dec.jump              = 1'b1;
                dec.reg_write         = 1'b1;
                dec.result_src        = RES_PC4;
                dec.imm_type          = IMM_J;
                dec.pc_target_src_sel = PC_TGT_PC;
            end
            OP_JALR: begin
                dec.jump              = 1'b1;
                dec.reg_write         = 1'b1;
                dec.result_src        = RES_PC4;
                dec.alu_src           = 1'b1;
                dec.imm_type          = IMM_I;
                dec.pc_target_src_sel = PC_TGT_RS1;
                dec.illegal           = (funct3_d_i != 3'b000);
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_type  = IMM_U;
                dec.op_a_sel  = ALU_A_ZERO;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_type  = IMM_U;
                dec.op_a_sel  = ALU_A_PC;
            end
            default: dec.illegal = 1'b1;
        endcase
        // an unrecognised encoding must never write state or redirect the PC
        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_write = 1'b0;
            dec.jump      = 1'b0;
            dec.branch    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e <= 1'b0;
            ctrl_e  <= '0;
        end else if (flush_e_i) begin
            valid_e <= 1'b0;
            ctrl_e  <= '0;
        end else if (!busy) begin
            if (hazard_stall_i || !valid_d_i) begin
                valid_e <= 1'b0;
                ctrl_e  <= '0;
            end else begin
                valid_e <= 1'b1;
                ctrl_e  <= dec;
            end
        end
    end

`ifdef CTRL_RV32M_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             start_q;
    logic             done_q;
    logic             load_muldiv;

    assign load_muldiv = valid_d_i && !hazard_stall_i && (op_d_i == OP_REG) && funct7_0_d_i;

    // done is registered one cycle early so it coincides with the cnt==1 cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (flush_e_i) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_muldiv) begin
                            state   <= ST_BUSY;
                            cnt     <= CNT_LOAD;
                            start_q <= 1'b1;
                            done_q  <= (CNT_LOAD == CNT_W'(1));
                        end
                    end
                    ST_BUSY: begin
                        cnt    <= cnt - 1'b1;
                        done_q <= (cnt == CNT_W'(2));
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy             = (state == ST_BUSY);
    assign stall_req_o      = busy;
    assign muldiv_start_e_o = start_q;
    assign muldiv_done_e_o  = done_q;
`else
    assign busy             = 1'b0;
    assign stall_req_o      = 1'b0;
    assign muldiv_start_e_o = 1'b0;
    assign muldiv_done_e_o  = 1'b0;
`endif

    assign valid_e_o             = valid_e;
    assign reg_write_e_o         = ctrl_e.reg_write;
    assign result_src_e_o        = ctrl_e.result_src;
    assign mem_write_e_o         = ctrl_e.mem_write;
    assign jump_e_o              = ctrl_e.jump;
    assign branch_e_o            = ctrl_e.branch;
    assign alu_src_e_o           = ctrl_e.alu_src;
    assign alu_control_e_o       = ctrl_e.alu_control;
    assign imm_type_e_o          = ctrl_e.imm_type;
    assign funct3_e_o            = ctrl_e.funct3;
    assign op_a_sel_e_o          = ctrl_e.op_a_sel;
    assign pc_target_src_sel_e_o = ctrl_e.pc_target_src_sel;
    assign illegal_e_o           = ctrl_e.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed and randomized checks of decode_ctrl_pipe against an
// occupancy-based reference model of the E stage.
`ifndef ALU_CONTROL_ADD
`define ALU_CONTROL_ADD    0
`define ALU_CONTROL_SUB    1
`define ALU_CONTROL_AND    2
`define ALU_CONTROL_OR     3
`define ALU_CONTROL_XOR    4
`define ALU_CONTROL_SLT    5
`define ALU_CONTROL_SLTU   6
`define ALU_CONTROL_SLL    7
`define ALU_CONTROL_SRL    8
`define ALU_CONTROL_SRA    9
`define ALU_CONTROL_MUL    10
`define ALU_CONTROL_MULH   11
`define ALU_CONTROL_MULHSU 12
`define ALU_CONTROL_MULHU  13
`define ALU_CONTROL_DIV    14
`define ALU_CONTROL_DIVU   15
`define ALU_CONTROL_REM    16
`define ALU_CONTROL_REMU   17
`endif

module tb_decode_ctrl_pipe;
    import decode_ctrl_pipe_pkg::*;

    localparam int LAT = 4;
`ifdef CTRL_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [4:0] A_ADD  = 5'(`ALU_CONTROL_ADD);
    localparam logic [4:0] A_SUB  = 5'(`ALU_CONTROL_SUB);
    localparam logic [4:0] A_SRA  = 5'(`ALU_CONTROL_SRA);
    localparam logic [4:0] A_MUL  = 5'(`ALU_CONTROL_MUL);
    localparam logic [4:0] A_BASE [8] = '{5'(`ALU_CONTROL_ADD), 5'(`ALU_CONTROL_SLL),
                                          5'(`ALU_CONTROL_SLT), 5'(`ALU_CONTROL_SLTU),
                                          5'(`ALU_CONTROL_XOR), 5'(`ALU_CONTROL_SRL),
                                          5'(`ALU_CONTROL_OR),  5'(`ALU_CONTROL_AND)};

    localparam logic [6:0] OPC [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                        7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                        7'b0010111, 7'b1110011, 7'b0001111};

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       j;
        logic       b;
        logic       as;
        logic [4:0] alu;
        logic [2:0] imm;
        logic [2:0] f3;
        logic [1:0] opa;
        logic       pct;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_d = 1'b0;
    logic [6:0] op_d = '0;
    logic [2:0] f3_d = '0;
    logic f75_d = 1'b0;
    logic f70_d = 1'b0;
    logic hazard = 1'b0;
    logic flush = 1'b0;

    logic valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, illegal_e;
    logic [1:0] result_src_e;
    logic [4:0] alu_control_e;
    logic [2:0] funct3_e;
    immediate_type_e imm_type_e;
    alu_a_src_sel_e op_a_sel_e;
    pc_target_src_sel_e pc_tgt_e;
    logic start_e, done_e, stall_req;

    int unsigned checks = 0;
    int unsigned errors = 0;

    exp_t exp_e = '0;
    logic exp_valid = 1'b0;
    int occ = 0;

    decode_ctrl_pipe #(.ALU_CTRL_W(5), .MULDIV_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_d_i(valid_d), .op_d_i(op_d), .funct3_d_i(f3_d),
        .funct7_5_d_i(f75_d), .funct7_0_d_i(f70_d), .hazard_stall_i(hazard), .flush_e_i(flush),
        .valid_e_o(valid_e), .reg_write_e_o(reg_write_e), .result_src_e_o(result_src_e),
        .mem_write_e_o(mem_write_e), .jump_e_o(jump_e), .branch_e_o(branch_e),
        .alu_src_e_o(alu_src_e), .alu_control_e_o(alu_control_e), .imm_type_e_o(imm_type_e),
        .funct3_e_o(funct3_e), .op_a_sel_e_o(op_a_sel_e), .pc_target_src_sel_e_o(pc_tgt_e),
        .illegal_e_o(illegal_e), .muldiv_start_e_o(start_e), .muldiv_done_e_o(done_e),
        .stall_req_o(stall_req)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f75, input logic f70);
        exp_t e;
        bit ok;
        e = '0;
        ok = 1'b1;
        e.f3 = f3;
        case (op)
            7'b0000011: begin e.rw = 1; e.rs = 2'd1; e.as = 1; e.alu = A_ADD; e.imm = IMM_I;
                              ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
            7'b0100011: begin e.mw = 1; e.as = 1; e.alu = A_ADD; e.imm = IMM_S; ok = (f3 <= 3'd2); end
            7'b0110011: begin
                e.rw = 1;
                if (f70) begin
                    ok = M_EN;
                    if (M_EN) e.alu = A_MUL + 5'(f3);
                end else begin
                    e.alu = (f3 == 3'd0 && f75) ? A_SUB : (f3 == 3'd5 && f75) ? A_SRA : A_BASE[f3];
                end
            end
            7'b0010011: begin e.rw = 1; e.as = 1; e.imm = IMM_I;
                              e.alu = (f3 == 3'd5 && f75) ? A_SRA : A_BASE[f3]; end
            7'b1100011: begin e.b = 1; e.alu = A_SUB; e.imm = IMM_B; ok = !(f3 == 3'd2 || f3 == 3'd3); end
            7'b1101111: begin e.j = 1; e.rw = 1; e.rs = 2'd2; e.imm = IMM_J; e.pct = PC_TGT_PC; end
            7'b1100111: begin e.j = 1; e.rw = 1; e.rs = 2'd2; e.as = 1; e.imm = IMM_I;
                              e.pct = PC_TGT_RS1; ok = (f3 == 3'd0); end
            7'b0110111: begin e.rw = 1; e.as = 1; e.imm = IMM_U; e.opa = ALU_A_ZERO; end
            7'b0010111: begin e.rw = 1; e.as = 1; e.imm = IMM_U; e.opa = ALU_A_PC; end
            default:    ok = 1'b0;
        endcase
        if (!ok) begin
            e.rw = 0; e.mw = 0; e.j = 0; e.b = 0; e.ill = 1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic verify(input string tag);
        exp_t ob;
        logic es, ed, est;
        ob = {reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_src_e, alu_control_e,
              3'(imm_type_e), funct3_e, 2'(op_a_sel_e), 1'(pc_tgt_e), illegal_e};
        es  = (occ == 1);
        est = (occ >= 1) && (occ <= LAT - 1);
        ed  = (occ == LAT - 1);
        check({tag, "_valid"}, 32'(valid_e), 32'(exp_valid));
        check({tag, "_bundle"}, 32'(ob), 32'(exp_e));
        check({tag, "_muldiv"}, {29'd0, start_e, done_e, stall_req}, {29'd0, es, ed, est});
    endtask

    // advance one edge; the model consumes the inputs present at that edge
    task automatic step();
        bit busy_now;
        busy_now = (occ >= 1) && (occ <= LAT - 1);
        if (flush) begin
            exp_valid = 0; exp_e = '0; occ = 0;
        end else if (busy_now) begin
            occ++;
        end else if (hazard || !valid_d) begin
            exp_valid = 0; exp_e = '0; occ = 0;
        end else begin
            exp_valid = 1;
            exp_e = ref_decode(op_d, f3_d, f75_d, f70_d);
            occ = (M_EN && op_d == 7'b0110011 && f70_d) ? 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic f75, input logic f70, input logic hz, input logic fl);
        valid_d = v; op_d = op; f3_d = f3; f75_d = f75; f70_d = f70; hazard = hz; flush = fl;
    endtask

    initial begin
        #3;
        verify("reset");
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 7'b0110011, 3'd0, 0, 0, 0, 0); step(); verify("t2_add");
        check("t2_alu_ctrl", 32'(alu_control_e), 32'(A_ADD));
        check("t2_alu_src", 32'(alu_src_e), 32'd0);

        drive(1, 7'b0000011, 3'd2, 0, 0, 1, 0); step(); verify("t3_bubble");
        check("t3_bubble_rw", 32'(reg_write_e), 32'd0);
        hazard = 0; step(); verify("t3_lw");
        check("t3_lw_rs", 32'(result_src_e), 32'd1);

        drive(1, 7'b0110011, 3'd0, 0, 1, 0, 0); step(); verify("t4_c1");
        drive(1, 7'b0110011, 3'd0, 1, 0, 0, 0);
        for (int i = 2; i <= LAT; i++) begin step(); verify($sformatf("t4_c%0d", i)); end
        step(); verify("t4_next");
`ifndef CTRL_RV32M_EN
        check("t6_stall", 32'(stall_req), 32'd0);
`endif

        drive(1, 7'b0110011, 3'd4, 0, 1, 0, 0); step(); verify("t5_c1");
        step(); verify("t5_c2");
        flush = 1; step(); verify("t5_flushed");
        check("t5_stall", 32'(stall_req), 32'd0);
        flush = 0; valid_d = 0; step(); verify("t5_after");
        check("t5_no_done", 32'(done_e), 32'd0);

        drive(1, 7'b0110011, 3'd1, 0, 1, 0, 0);
        for (int i = 0; i < 2 * LAT + 1; i++) begin step(); verify($sformatf("b2b_%0d", i)); end

        drive(1, 7'b0110011, 3'd5, 0, 1, 0, 1); step(); verify("start_vs_flush");
        drive(0, 7'b0110011, 3'd0, 0, 0, 0, 0); step(); verify("invalid_d");
        drive(1, 7'b1110011, 3'd0, 0, 0, 0, 0); step(); verify("illegal_op");
        check("illegal_flag", 32'(illegal_e), 32'd1);

`ifndef CTRL_RV32M_EN
        drive(1, 7'b0110011, 3'd0, 0, 1, 0, 0); step(); verify("t6_muldiv_off");
        check("t6_illegal", 32'(illegal_e), 32'd1);
        check("t6_rw", 32'(reg_write_e), 32'd0);
`endif

        drive(1, 7'b0110011, 3'd6, 0, 1, 0, 0); step(); verify("t1_pre");
        valid_d = 0; step(); verify("t1_busy");
        rst_n = 0; #1;
        exp_valid = 0; exp_e = '0; occ = 0;
        verify("t1_async");
        #1 rst_n = 1;
        step(); verify("t1_released");

        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            op = OPC[$urandom_range(0, 10)];
            drive(($urandom_range(0, 99) < 85), op, 3'($urandom), 1'($urandom),
                  (op == 7'b0110011) ? ($urandom_range(0, 99) < 40) : 1'($urandom),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
            step();
            verify($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
